cdb_arbiter: RTL and testbench

//   Arbitrates completion results from the adder, multiplier and fetch units onto one

---
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished result per cycle from the adder,
// multiplier and fetch units using a round-robin pointer. The winner is broadcast
// as {tag, data} from a registered stage with a ready handshake. A saturating
// counter tracks the cycles in which some requester was turned away.
module cdb_arbiter #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_req,
    input  logic              add_rs,
    input  logic [DATA_W-1:0] add_data,
    output logic              add_grant,
    input  logic              mult_req,
    input  logic              mult_rs,
    input  logic [DATA_W-1:0] mult_data,
    output logic              mult_grant,
    input  logic              fetch_req,
    input  logic              fetch_rs,
    input  logic [DATA_W-1:0] fetch_data,
    output logic              fetch_grant,
    input  logic              cdb_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // Requester indices; SEL_NONE means nobody wins this cycle.
    localparam logic [1:0] SEL_ADD   = 2'd0;
    localparam logic [1:0] SEL_MULT  = 2'd1;
    localparam logic [1:0] SEL_FETCH = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    // A station's tag is its unit base plus the station index within the unit.
    localparam logic [TAG_W-1:0] TAG_ADD_BASE   = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_MULT_BASE  = TAG_W'(3);
    localparam logic [TAG_W-1:0] TAG_FETCH_BASE = TAG_W'(5);

    // Round-robin pointer: the requester that gets first look next cycle.
    logic [1:0]        rr_ptr;

    // Broadcast stage registers.
    logic              cdb_vld_p1;
    logic [TAG_W-1:0]  cdb_tag_p1;
    logic [DATA_W-1:0] cdb_data_p1;
    logic [CNT_W-1:0]  conflict_cnt_q;

    // Arbitration-cycle signals.
    logic              accept;
    logic [2:0]        req_vec;
    logic [1:0]        win_sel;
    logic [2:0]        grant_vec;
    logic [TAG_W-1:0]  win_tag_p0;
    logic [DATA_W-1:0] win_data_p0;
    logic              denied;

    // First requester at or after ptr in the cyclic order add -> mult -> fetch.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] sel;
        case (ptr)
            SEL_MULT:  sel = req[1] ? SEL_MULT  : req[2] ? SEL_FETCH : req[0] ? SEL_ADD   : SEL_NONE;
            SEL_FETCH: sel = req[2] ? SEL_FETCH : req[0] ? SEL_ADD   : req[1] ? SEL_MULT  : SEL_NONE;
            default:   sel = req[0] ? SEL_ADD   : req[1] ? SEL_MULT  : req[2] ? SEL_FETCH : SEL_NONE;
        endcase
        return sel;
    endfunction

    // Pointer moves to the requester just after the winner, wrapping at three.
    function automatic logic [1:0] rr_next(input logic [1:0] sel);
        return (sel == SEL_FETCH) ? SEL_ADD : sel + 2'd1;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Pick a winner when the output slot is free or draining, and form its tag/data.
    always_comb begin
        accept      = !rst && (!cdb_vld_p1 || cdb_ready);
        req_vec     = {fetch_req, mult_req, add_req};
        win_sel     = accept ? rr_pick(req_vec, rr_ptr) : SEL_NONE;
        grant_vec   = 3'b000;
        win_tag_p0  = '0;
        win_data_p0 = '0;
        case (win_sel)
            SEL_ADD: begin
                grant_vec   = 3'b001;
                win_tag_p0  = TAG_ADD_BASE + TAG_W'(add_rs);
                win_data_p0 = add_data;
            end
            SEL_MULT: begin
                grant_vec   = 3'b010;
                win_tag_p0  = TAG_MULT_BASE + TAG_W'(mult_rs);
                win_data_p0 = mult_data;
            end
            SEL_FETCH: begin
                grant_vec   = 3'b100;
                win_tag_p0  = TAG_FETCH_BASE + TAG_W'(fetch_rs);
                win_data_p0 = fetch_data;
            end
            default: begin
                grant_vec   = 3'b000;
            end
        endcase
        // Any raised request left without a grant makes this a conflict cycle.
        denied = |(req_vec & ~grant_vec);
    end

    assign add_grant   = grant_vec[0];
    assign mult_grant  = grant_vec[1];
    assign fetch_grant = grant_vec[2];

    // Stage p0 -> p1: load the winner into the broadcast slot, advance the pointer, count conflicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_vld_p1     <= 1'b0;
            cdb_tag_p1     <= '0;
            cdb_data_p1    <= '0;
            conflict_cnt_q <= '0;
            rr_ptr         <= SEL_ADD;
        end else begin
            if (denied) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end
            if (accept) begin
                cdb_vld_p1 <= |grant_vec;
                if (|grant_vec) begin
                    cdb_tag_p1  <= win_tag_p0;
                    cdb_data_p1 <= win_data_p0;
                    rr_ptr      <= rr_next(win_sel);
                end
            end
        end
    end

    assign cdb_valid    = cdb_vld_p1;
    assign cdb_tag      = cdb_tag_p1;
    assign cdb_data     = cdb_data_p1;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a behavioural model predicts grants, broadcast contents
// and the conflict counter; predicted broadcasts queue up and are checked when
// they reach the bus.
module tb_cdb_arbiter;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              add_req, add_rs, add_grant;
    logic [DATA_W-1:0] add_data;
    logic              mult_req, mult_rs, mult_grant;
    logic [DATA_W-1:0] mult_data;
    logic              fetch_req, fetch_rs, fetch_grant;
    logic [DATA_W-1:0] fetch_data;
    logic              cdb_ready, cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [CNT_W-1:0]  conflict_cnt;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .add_req(add_req), .add_rs(add_rs), .add_data(add_data), .add_grant(add_grant),
        .mult_req(mult_req), .mult_rs(mult_rs), .mult_data(mult_data), .mult_grant(mult_grant),
        .fetch_req(fetch_req), .fetch_rs(fetch_rs), .fetch_data(fetch_data), .fetch_grant(fetch_grant),
        .cdb_ready(cdb_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [1:0]        m_ptr;
    logic              m_vld;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_cnt;
    logic [2:0]        exp_gnt;
    ent_t              sbq[$];

    function automatic logic [2:0] gnts();
        return {fetch_grant, mult_grant, add_grant};
    endfunction

    // Predict this cycle's grants from the current inputs and model state.
    task automatic model_eval();
        logic acc;
        logic [2:0] req;
        req = {fetch_req, mult_req, add_req};
        exp_gnt = 3'b000;
        acc = !rst && (!m_vld || cdb_ready);
        if (acc) begin
            for (int i = 0; i < 3; i++) begin
                int k;
                k = (int'(m_ptr) + i) % 3;
                if (req[k] && exp_gnt == 3'b000) exp_gnt[k] = 1'b1;
            end
        end
    endtask

    // Advance the model by one clock, then clock the DUT.
    task automatic tick();
        logic acc;
        logic [2:0] req;
        int k;
        ent_t e;
        model_eval();
        req = {fetch_req, mult_req, add_req};
        acc = !rst && (!m_vld || cdb_ready);
        if (rst) begin
            m_vld = 1'b0; m_tag = '0; m_data = '0; m_cnt = '0; m_ptr = 2'd0;
        end else begin
            if ((req & ~exp_gnt) != 3'b000 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (acc) begin
                if (exp_gnt != 3'b000) begin
                    k = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
                    case (k)
                        0: begin e.tag = 4'(1 + int'(add_rs));   e.data = add_data;   end
                        1: begin e.tag = 4'(3 + int'(mult_rs));  e.data = mult_data;  end
                        default: begin e.tag = 4'(5 + int'(fetch_rs)); e.data = fetch_data; end
                    endcase
                    m_vld = 1'b1; m_tag = e.tag; m_data = e.data;
                    sbq.push_back(e);
                    m_ptr = 2'((k + 1) % 3);
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        add_req = 0; mult_req = 0; fetch_req = 0;
        add_rs = 0; mult_rs = 0; fetch_rs = 0;
        add_data = '0; mult_data = '0; fetch_data = '0;
        cdb_ready = 1'b0;
        tick();
        add_req = 1; mult_req = 1;
        #1;
        tests++;
        if (gnts() !== 3'b000) begin fails++; $display("FAIL reset_grants: got %b want 000", gnts()); end
        tick();
        rst = 1'b0; add_req = 0; mult_req = 0;
        #1;
        tests++;
        if (cdb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
        tests++;
        if (cdb_tag !== 4'd0) begin fails++; $display("FAIL reset_tag: got %0d want 0", cdb_tag); end
        tests++;
        if (cdb_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", cdb_data); end
        tests++;
        if (conflict_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
        tests++;
        if (gnts() !== 3'b000) begin fails++; $display("FAIL idle_grants: got %b want 000", gnts()); end
    endtask

    task automatic test_single();
        ent_t e;
        mult_req = 1; mult_rs = 1; mult_data = 8'h2A; cdb_ready = 1;
        #1;
        model_eval();
        tests++;
        if (gnts() !== exp_gnt) begin fails++; $display("FAIL single_grant: got %b want %b", gnts(), exp_gnt); end
        tests++;
        if (mult_grant !== 1'b1) begin fails++; $display("FAIL single_mult_grant: got %b want 1", mult_grant); end
        tick();
        mult_req = 0;
        tests++;
        if (cdb_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
        tests++;
        if (sbq.size() == 0) begin fails++; $display("FAIL single_sb: scoreboard empty, want one entry"); end
        else begin
            e = sbq.pop_front();
            if ({cdb_tag, cdb_data} !== e) begin fails++; $display("FAIL single_bus: got %h want %h", {cdb_tag, cdb_data}, e); end
        end
        tests++;
        if (cdb_tag !== 4'd4 || cdb_data !== 8'h2A) begin fails++; $display("FAIL single_tag4: got %0d/%h want 4/2a", cdb_tag, cdb_data); end
        tick();
        tests++;
        if (cdb_valid !== m_vld) begin fails++; $display("FAIL single_drain: got %b want %b", cdb_valid, m_vld); end
        tests++;
        if (conflict_cnt !== m_cnt) begin fails++; $display("FAIL single_cnt: got %0d want %0d", conflict_cnt, m_cnt); end
    endtask

    // All three units request continuously; also covers back-to-back streaming.
    task automatic test_round_robin();
        ent_t e;
        logic [2:0] g;
        cdb_ready = 1;
        add_req = 1; mult_req = 1; fetch_req = 1;
        add_rs = 0; mult_rs = 1; fetch_rs = 0;
        add_data = 8'hA0; mult_data = 8'hB1; fetch_data = 8'hC2;
        for (int n = 0; n < 9; n++) begin
            #1;
            model_eval();
            tests++;
            if (gnts() !== exp_gnt) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", n, gnts(), exp_gnt); end
            g = exp_gnt;
            tick();
            tests++;
            if (cdb_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b want 1", n, cdb_valid); end
            tests++;
            if (sbq.size() == 0) begin fails++; $display("FAIL rr_sb[%0d]: scoreboard empty", n); end
            else begin
                e = sbq.pop_front();
                if ({cdb_tag, cdb_data} !== e) begin fails++; $display("FAIL rr_bus[%0d]: got %h want %h", n, {cdb_tag, cdb_data}, e); end
            end
            tests++;
            if (conflict_cnt !== m_cnt) begin fails++; $display("FAIL rr_cnt[%0d]: got %0d want %0d", n, conflict_cnt, m_cnt); end
            // The granted unit presents its next result.
            if (g[0]) begin add_rs = 1'($urandom_range(0, 1));   add_data = 8'($urandom);   end
            if (g[1]) begin mult_rs = 1'($urandom_range(0, 1));  mult_data = 8'($urandom);  end
            if (g[2]) begin fetch_rs = 1'($urandom_range(0, 1)); fetch_data = 8'($urandom); end
        end
    endtask

    task automatic test_backpressure();
        ent_t e;
        logic [CNT_W-1:0] cnt0;
        add_req = 0; mult_req = 0; fetch_req = 1; fetch_rs = 0; fetch_data = 8'h5C;
        cdb_ready = 1;
        #1;
        tick();
        fetch_req = 0;
        if (sbq.size() != 0) e = sbq.pop_front();
        tests++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'd5) begin fails++; $display("FAIL bp_setup: got %b/%0d want 1/5", cdb_valid, cdb_tag); end
        cnt0 = m_cnt;
        cdb_ready = 0; add_req = 1; add_rs = 1; add_data = 8'h11;
        for (int n = 0; n < 3; n++) begin
            #1;
            tests++;
            if (gnts() !== 3'b000) begin fails++; $display("FAIL bp_nogrant[%0d]: got %b want 000", n, gnts()); end
            tick();
            tests++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 4'd5 || cdb_data !== 8'h5C) begin
                fails++; $display("FAIL bp_hold[%0d]: got %b/%0d/%h want 1/5/5c", n, cdb_valid, cdb_tag, cdb_data);
            end
        end
        tests++;
        if (conflict_cnt !== cnt0 + 8'd3) begin fails++; $display("FAIL bp_cnt: got %0d want %0d", conflict_cnt, cnt0 + 8'd3); end
        cdb_ready = 1;
        #1;
        tests++;
        if (add_grant !== 1'b1) begin fails++; $display("FAIL bp_release_grant: got %b want 1", add_grant); end
        tick();
        add_req = 0;
        tests++;
        if (sbq.size() == 0) begin fails++; $display("FAIL bp_sb: scoreboard empty"); end
        else begin
            e = sbq.pop_front();
            if ({cdb_tag, cdb_data} !== e) begin fails++; $display("FAIL bp_bus: got %h want %h", {cdb_tag, cdb_data}, e); end
        end
        tests++;
        if (cdb_tag !== 4'd2) begin fails++; $display("FAIL bp_tag: got %0d want 2", cdb_tag); end
    endtask

    task automatic test_saturation();
        cdb_ready = 0; add_req = 1; mult_req = 1;
        for (int n = 0; n < 300; n++) tick();
        tests++;
        if (conflict_cnt !== 8'hFF) begin fails++; $display("FAIL sat_cnt: got %h want ff", conflict_cnt); end
        tests++;
        if (conflict_cnt !== m_cnt) begin fails++; $display("FAIL sat_model: got %h want %h", conflict_cnt, m_cnt); end
        tests++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2) begin fails++; $display("FAIL sat_hold: got %b/%0d want 1/2", cdb_valid, cdb_tag); end
        add_req = 0; mult_req = 0;
    endtask

    task automatic test_reset_mid();
        ent_t e;
        cdb_ready = 1; add_req = 0; fetch_req = 0;
        mult_req = 1; mult_rs = 0; mult_data = 8'h33;
        #1;
        tick();
        if (sbq.size() != 0) e = sbq.pop_front();
        mult_req = 0; cdb_ready = 0; add_req = 1;
        tick();
        tests++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3) begin fails++; $display("FAIL rm_stall: got %b/%0d want 1/3", cdb_valid, cdb_tag); end
        rst = 1;
        #1;
        tests++;
        if (gnts() !== 3'b000) begin fails++; $display("FAIL rm_rst_grants: got %b want 000", gnts()); end
        tick();
        rst = 0;
        tests++;
        if (cdb_valid !== 1'b0 || conflict_cnt !== 8'd0) begin
            fails++; $display("FAIL rm_cleared: got %b/%0d want 0/0", cdb_valid, conflict_cnt);
        end
        add_req = 1; mult_req = 1; fetch_req = 1; cdb_ready = 1;
        add_rs = 0; add_data = 8'h77;
        #1;
        model_eval();
        tests++;
        if (gnts() !== 3'b001 || gnts() !== exp_gnt) begin fails++; $display("FAIL rm_adder_first: got %b want 001", gnts()); end
        tick();
        add_req = 0; mult_req = 0; fetch_req = 0;
        tests++;
        if (sbq.size() == 0) begin fails++; $display("FAIL rm_sb: scoreboard empty"); end
        else begin
            e = sbq.pop_front();
            if ({cdb_tag, cdb_data} !== e) begin fails++; $display("FAIL rm_bus: got %h want %h", {cdb_tag, cdb_data}, e); end
        end
        tick();
        tests++;
        if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rm_idle: got %b want 0", cdb_valid); end
        tests++;
        if (sbq.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d entries want 0", sbq.size()); end
    endtask

    initial begin
        m_ptr = 2'd0; m_vld = 1'b0; m_tag = '0; m_data = '0; m_cnt = '0; exp_gnt = 3'b000;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
